// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/response bundle for the multi-cycle shifter.
// The master drives requests and consumes results; the slave is the shifter.
interface seq_shifter_if #(
  parameter int XLEN = 32
) ();
  localparam int SHW = $clog2(XLEN);

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] data_in;
  logic [SHW-1:0]  shamt;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] data_out;
  logic            busy;

  modport master (
    output in_valid, op, data_in, shamt, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, op, data_in, shamt, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle SLL/SRL/SRA (optional ROR) shifter retiring up to
// STEP bit positions per clock, with valid/ready on both sides.
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN (op=11 rotates right when
// defined; otherwise op=11 passes the operand through in one cycle).
module seq_shifter #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  seq_shifter_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);
`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam logic [1:0]   OP_ROR = 2'b11;
  localparam logic [SHW:0] XLEN_W = (SHW+1)'(XLEN);
`endif

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] data_out_q, data_out_d;
  logic            out_valid_q, out_valid_d;

  logic [SHW:0]    k;
  logic [XLEN-1:0] shifted;
  logic            pass_through;

  // Bits retired this cycle: the smaller of STEP and what is still left.
  always_comb begin
    if ({1'b0, rem_q} < STEP_W) k = {1'b0, rem_q};
    else                        k = STEP_W;
  end

  // One partial shift of the accumulator by k according to the latched op.
  always_comb begin
    shifted = acc_q;
    case (op_q)
      OP_SLL:  shifted = acc_q << k;
      OP_SRL:  shifted = acc_q >> k;
      OP_SRA:  shifted = XLEN'($signed(acc_q) >>> k);
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROR:  shifted = (acc_q >> k) | (acc_q << (XLEN_W - k));
`endif
      default: shifted = acc_q;
    endcase
  end

  // Without rotate support, op=11 forces a zero remaining count so the
  // operand comes straight back after one cycle.
`ifdef SEQ_SHIFTER_ROTATE_EN
  assign pass_through = 1'b0;
`else
  assign pass_through = (bus.op == 2'b11);
`endif

  // Next-state and datapath control for IDLE -> BUSY -> DONE.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    op_d        = op_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          acc_d   = bus.data_in;
          op_d    = bus.op;
          rem_d   = pass_through ? '0 : bus.shamt;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (rem_q == '0) begin
          data_out_d  = acc_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          acc_d = shifted;
          rem_d = rem_q - k[SHW-1:0];
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      op_q        <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: drives a STEP=1 and a STEP=4 shifter with identical requests
// and compares results and latencies against an arithmetic reference.
module tb_seq_shifter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_shifter_if #(.XLEN(32)) if1 ();
  seq_shifter_if #(.XLEN(32)) if4 ();

  seq_shifter #(.XLEN(32), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_shifter #(.XLEN(32), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the shift rules.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] d, input int s);
    logic [63:0] dd;
    dd = {d, d};
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
`ifdef SEQ_SHIFTER_ROTATE_EN
      default: return 32'(dd >> s);
`else
      default: return d;
`endif
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input int s, input int step);
`ifndef SEQ_SHIFTER_ROTATE_EN
    if (op == 2'b11) return 1;
`endif
    return (s + step - 1) / step + 1;
  endfunction

  task automatic drive_in(input logic v, input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    if1.in_valid = v; if1.op = op; if1.data_in = d; if1.shamt = s;
    if4.in_valid = v; if4.op = op; if4.data_in = d; if4.shamt = s;
  endtask

  task automatic set_ready(input logic r);
    if1.out_ready = r;
    if4.out_ready = r;
  endtask

  // One transaction on both DUTs; called at a negedge with both idle.
  task automatic run_txn(input string name, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] s, input bit hold);
    int cyc, lat1, lat4;
    logic [31:0] got1, got4, exp;
    bit bad;
    exp = ref_result(op, d, int'(s));
    lat1 = -1; lat4 = -1; got1 = '0; got4 = '0; bad = 0; cyc = 0;
    set_ready(!hold);
    drive_in(1'b1, op, d, s);
    @(posedge clk);
    #1 drive_in(1'b0, 2'($urandom), $urandom, 5'($urandom));
    while ((lat1 < 0 || lat4 < 0) && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (lat1 < 0) begin
        if (if1.out_valid) begin lat1 = cyc; got1 = if1.data_out; end
        else if (!if1.busy || if1.in_ready) bad = 1;
      end else if (hold && (!if1.out_valid || if1.data_out !== got1 || if1.in_ready)) bad = 1;
      if (lat4 < 0) begin
        if (if4.out_valid) begin lat4 = cyc; got4 = if4.data_out; end
        else if (!if4.busy || if4.in_ready) bad = 1;
      end else if (hold && (!if4.out_valid || if4.data_out !== got4 || if4.in_ready)) bad = 1;
    end
    $display("txn %s op=%0d d=0x%08h s=%0d hold=%0d: s1 0x%08h lat %0d, s4 0x%08h lat %0d, exp 0x%08h",
             name, op, d, s, hold, got1, lat1, got4, lat4, exp);
    check({name, " result s1"}, 64'(got1), 64'(exp));
    check({name, " result s4"}, 64'(got4), 64'(exp));
    check({name, " latency s1"}, 64'(lat1), 64'(ref_lat(op, int'(s), 1)));
    check({name, " latency s4"}, 64'(lat4), 64'(ref_lat(op, int'(s), 4)));
    check({name, " busy/hold"}, 64'(bad), 64'(0));
    if (hold) begin
      // Backpressure: result must stay put and new requests must be ignored.
      bad = 0;
      for (int i = 0; i < 5; i++) begin
        drive_in(1'b1, 2'($urandom), $urandom, 5'($urandom));
        @(negedge clk);
        if (!if1.out_valid || if1.data_out !== exp || if1.in_ready) bad = 1;
        if (!if4.out_valid || if4.data_out !== exp || if4.in_ready) bad = 1;
      end
      check({name, " backpressure"}, 64'(bad), 64'(0));
      set_ready(1'b1);
    end
    // Release edge: with in_valid still possibly high, no accept may happen here.
    @(negedge clk);
    drive_in(1'b0, 2'($urandom), $urandom, 5'($urandom));
    check({name, " idle after s1"}, {if1.in_ready, if1.out_valid, if1.busy, if1.data_out},
          {1'b1, 1'b0, 1'b0, exp});
    check({name, " idle after s4"}, {if4.in_ready, if4.out_valid, if4.busy, if4.data_out},
          {1'b1, 1'b0, 1'b0, exp});
  endtask

  initial begin
    bit bad;
    drive_in(1'b0, 2'b00, '0, '0);
    set_ready(1'b0);
    #2;
    check("reset s1", {if1.in_ready, if1.out_valid, if1.busy, if1.data_out}, {1'b1, 1'b0, 1'b0, 32'h0});
    check("reset s4", {if4.in_ready, if4.out_valid, if4.busy, if4.data_out}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    run_txn("sll_3_1",   2'b00, 32'h0000_0003, 5'd1,  1'b0);
    run_txn("sll_5_2",   2'b00, 32'h0000_0005, 5'd2,  1'b0);
    run_txn("sra_sign",  2'b10, 32'h8000_0010, 5'd4,  1'b0);
    run_txn("srl_4",     2'b01, 32'h8000_0010, 5'd4,  1'b0);
    run_txn("shamt0",    2'b00, 32'hDEAD_BEEF, 5'd0,  1'b0);
    run_txn("srl_31",    2'b01, 32'hFFFF_FFFF, 5'd31, 1'b0);
    run_txn("backpress", 2'b10, 32'hF0F0_1234, 5'd7,  1'b1);
    run_txn("after_bp",  2'b00, 32'h1234_5678, 5'd3,  1'b0);
    run_txn("op11",      2'b11, 32'h0000_0001, 5'd1,  1'b0);
    run_txn("op11_big",  2'b11, 32'hA5A5_0F0F, 5'd13, 1'b1);

    // Asynchronous reset in the middle of a long operation.
    set_ready(1'b1);
    drive_in(1'b1, 2'b01, 32'hCAFE_F00D, 5'd20);
    @(posedge clk);
    #1 drive_in(1'b0, 2'b00, '0, '0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset s1", {if1.in_ready, if1.out_valid, if1.busy, if1.data_out}, {1'b1, 1'b0, 1'b0, 32'h0});
    check("midreset s4", {if4.in_ready, if4.out_valid, if4.busy, if4.data_out}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    #2 rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if1.out_valid || if4.out_valid || !if1.in_ready || !if4.in_ready) bad = 1;
    end
    $display("txn midreset: no output after reset flag=%0d", bad);
    check("no stale output", 64'(bad), 64'(0));

    for (int n = 0; n < 30; n++) begin
      run_txn($sformatf("rnd%0d", n), 2'($urandom), $urandom, 5'($urandom_range(0, 31)),
              bit'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle, parametrised successor to the combinational `Shifter` used in the RV32IC datapath.
- Performs SLL/SRL/SRA, with optional rotate, on an XLEN-bit operand by a run-time shift amount.
- Retires up to STEP bit positions per clock, trading latency for area.
- Valid/ready handshakes on input and output; sits beside the ALU and stalls the pipeline through `busy`.

Parameters:
- XLEN, 32: operand/result width in bits; power of 2, minimum 8.
- STEP, 1: bit positions shifted per cycle; power of 2, 1..XLEN.
- SHW, $clog2(XLEN): shift-amount width; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (ROTATE_EN) or pass-through.
- data_in  input  XLEN  operand.
- shamt  input  SHW  shift amount, 0..XLEN-1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- data_out  output  XLEN  shifted result.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - State goes to IDLE.
  - data_out=0, out_valid=0, busy=0, in_ready=1.
  - Internal acc, remaining count and op register cleared.
  - Reset mid-operation discards the transaction; no output is produced.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: acc<=data_in, rem<=shamt, op latched, go to BUSY.
  - data_in, shamt and op are sampled only at acceptance.
- BUSY:
  - in_ready=0.
  - If rem==0: data_out<=acc, out_valid<=1, go to DONE.
  - Else k=min(STEP,rem): acc<=acc shifted by k per latched op, rem<=rem-k.
- Shift rules:
  - SLL: zero-fill on the LSB side.
  - SRL: zero-fill on the MSB side.
  - SRA: fill with acc[XLEN-1], the sign bit of the original operand.
  - ROR: bits shifted out of the LSB side re-enter at the MSB side.
- DONE:
  - out_valid=1 and data_out stable until out_ready=1.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE. in_ready is high again the next cycle; there is no same-cycle back-to-back accept.
  - data_out holds its last value after the handshake.
- Latency from accept edge to out_valid high = ceil(shamt/STEP)+1 cycles.
  - shamt=0 gives 1 cycle and data_out=data_in.
  - Example XLEN=32, STEP=1, shamt=31: 32 cycles.
- out_ready held high before DONE has no effect.
- in_valid while busy is ignored and not queued; the requester must hold the request until in_ready.
- shamt only spans 0..XLEN-1, so no over-range handling is needed.

Optional Feature:
- Macro SEQ_SHIFTER_ROTATE_EN.
- Defined: op=11 selects rotate-right.
- Undefined:
  - op=11 is a pass-through: result = data_in, latency 1 cycle regardless of shamt.
  - The rotate datapath is not synthesised.

Test Plan:
- Basic SLL, XLEN=32, STEP=1: data_in=3, shamt=1, op=00 -> data_out=6, out_valid 2 cycles after accept. Then data_in=5, shamt=2 -> 20.
- SRA sign fill: data_in=0x8000_0010, shamt=4, op=10, STEP=4 -> 0xF800_0001, latency 2 cycles. Same with op=01 -> 0x0800_0001.
- Boundaries, STEP=1:
  - shamt=0, op=00, data_in=0xDEAD_BEEF -> 0xDEAD_BEEF after 1 cycle.
  - shamt=31, op=01, data_in=0xFFFF_FFFF -> 0x0000_0001 after 32 cycles; busy high throughout.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and data_out stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle, then the new request is accepted.
- Async reset mid-BUSY: assert rst=0 between clock edges during a shamt=20 op -> outputs zeroed immediately, in_ready=1 after release, no stale out_valid.
- Rotate, macro defined: data_in=0x0000_0001, shamt=1, op=11 -> 0x8000_0000. Macro undefined -> 0x0000_0001 after 1 cycle.
